// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and field constants for the cpu_ctrl sequencer.
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_REG = 3'd5,
    S_WR_IMM = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic VSEL_C   = 1'b0;
  localparam logic VSEL_IMM = 1'b1;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_dec.sv
// instr_dec: combinational field split and immediate sign extension of the IR.
`default_nettype none

module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sext8(ir[7:0]);

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle Moore sequencer driving regfile, operand regs, shifter, ALU, status.
// Optional HALT state enabled by defining CPU_CTRL_HALT_EN.
`default_nettype none

module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic [15:0] sximm8,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        halted
);

  state_t      state;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  instr_dec u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm8 (sximm8)
  );

  logic is_alu;
  logic is_mov_reg;
  logic is_mov_imm;
  logic is_cmp;

  assign is_alu     = (opcode == OPC_ALU);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == MOV_REG);
  assign is_mov_imm = (opcode == OPC_MOV) && (op == MOV_IMM);
  assign is_cmp     = is_alu && (op == ALU_SUB);

`ifdef CPU_CTRL_HALT_EN
  logic halted_r;
  assign halted = halted_r;
`else
  assign halted = 1'b0;
`endif

  // Outputs are registered for the state being entered, so each one is a
  // function of the current state and IR only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT;
      ir       <= '0;
      w        <= 1'b1;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      vsel     <= VSEL_C;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      shift    <= '0;
      ALUop    <= ALU_ADD;
`ifdef CPU_CTRL_HALT_EN
      halted_r <= 1'b0;
`endif
    end else begin
      w        <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      vsel     <= VSEL_C;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      shift    <= '0;
      ALUop    <= ALU_ADD;

      case (state)
        S_WAIT: begin
          if (s) begin
            ir    <= in;
            state <= S_DECODE;
          end else begin
            w <= 1'b1;
          end
        end

        S_DECODE: begin
          if (is_mov_imm) begin
            state    <= S_WR_IMM;
            writenum <= rn;
            vsel     <= VSEL_IMM;
            write    <= 1'b1;
          end else if (is_mov_reg) begin
            state   <= S_GET_B;
            readnum <= rm;
            loadb   <= 1'b1;
            shift   <= sh;
          end else if (is_alu) begin
            state   <= S_GET_A;
            readnum <= rn;
            loada   <= 1'b1;
          end else if (opcode == OPC_HALT) begin
`ifdef CPU_CTRL_HALT_EN
            state    <= S_HALT;
            halted_r <= 1'b1;
`else
            state <= S_WAIT;
            w     <= 1'b1;
`endif
          end else begin
            state <= S_WAIT;
            w     <= 1'b1;
          end
        end

        S_GET_A: begin
          state   <= S_GET_B;
          readnum <= rm;
          loadb   <= 1'b1;
          shift   <= sh;
        end

        S_GET_B: begin
          state <= S_EXEC;
          shift <= sh;
          asel  <= is_mov_reg;
          ALUop <= is_alu ? op : ALU_ADD;
          if (is_cmp) loads <= 1'b1;
          else        loadc <= 1'b1;
        end

        S_EXEC: begin
          // CMP only updates status, so it has no register write-back.
          if (is_cmp) begin
            state <= S_WAIT;
            w     <= 1'b1;
          end else begin
            state    <= S_WR_REG;
            writenum <= rd;
            vsel     <= VSEL_C;
            write    <= 1'b1;
          end
        end

        S_WR_REG, S_WR_IMM: begin
          state <= S_WAIT;
          w     <= 1'b1;
        end

        S_HALT: begin
`ifdef CPU_CTRL_HALT_EN
          state    <= S_HALT;
          halted_r <= 1'b1;
`else
          state <= S_WAIT;
          w     <= 1'b1;
`endif
        end

        default: begin
          state <= S_WAIT;
          w     <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed vectors with an expected-strobe scoreboard for cpu_ctrl.
`default_nettype none

module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic [15:0] sximm8;
  logic        loada, loadb, loadc, loads;
  logic        asel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        halted;

  cpu_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .sximm8   (sximm8),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .shift    (shift),
    .ALUop    (ALUop),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       vsel;
    logic       asel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Fields are compared only where they carry meaning for the strobe raised.
  function automatic logic ev_match(input ev_t a, input ev_t e);
    logic ok;
    ok = ({a.loada, a.loadb, a.loadc, a.loads, a.write} ==
          {e.loada, e.loadb, e.loadc, e.loads, e.write});
    if (e.loada || e.loadb) ok = ok && (a.readnum == e.readnum);
    if (e.write) ok = ok && (a.writenum == e.writenum) && (a.vsel == e.vsel);
    if (e.loadb || e.loadc || e.loads) ok = ok && (a.shift == e.shift);
    if (e.loadc || e.loads) ok = ok && (a.aluop == e.aluop) && (a.asel == e.asel);
    return ok;
  endfunction

  task automatic push_a(input logic [2:0] rn);
    ev_t e = '0;
    e.loada = 1'b1; e.readnum = rn;
    exp_q.push_back(e);
  endtask

  task automatic push_b(input logic [2:0] rm, input logic [1:0] sh);
    ev_t e = '0;
    e.loadb = 1'b1; e.readnum = rm; e.shift = sh;
    exp_q.push_back(e);
  endtask

  task automatic push_c(input logic [1:0] aluop, input logic as, input logic [1:0] sh);
    ev_t e = '0;
    e.loadc = 1'b1; e.aluop = aluop; e.asel = as; e.shift = sh;
    exp_q.push_back(e);
  endtask

  task automatic push_s(input logic [1:0] aluop, input logic [1:0] sh);
    ev_t e = '0;
    e.loads = 1'b1; e.aluop = aluop; e.shift = sh;
    exp_q.push_back(e);
  endtask

  task automatic push_w(input logic [2:0] wn, input logic vs);
    ev_t e = '0;
    e.write = 1'b1; e.writenum = wn; e.vsel = vs;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle that raises a strobe must match the next expected event.
  ev_t mon_act;
  ev_t mon_exp;
  always @(negedge clk) begin
    mon_act = '{loada: loada, loadb: loadb, loadc: loadc, loads: loads, write: write,
                readnum: readnum, writenum: writenum, vsel: vsel, asel: asel,
                shift: shift, aluop: ALUop};
    if (loada || loadb || loadc || loads || write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: actual=%0h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (!ev_match(mon_act, mon_exp)) begin
          errors++;
          $display("FAIL strobe_event: actual=%0h required=%0h", mon_act, mon_exp);
        end
      end
    end
  end

  // Accepts one instruction and measures cycles from the accept edge until w returns.
  task automatic issue(input logic [15:0] instr, input int lat, input string name);
    int n;
    @(negedge clk);
    s  = 1'b1;
    in = instr;
    @(posedge clk);
    #1;
    s  = 1'b0;
    in = 16'($urandom);
    n  = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (w) break;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    s       = 1'b1;
    in      = 16'hD3FE;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_w", 32'(w), 32'd1);
    chk("reset_strobes", 32'({loada, loadb, loadc, loads, write}), 32'd0);
    chk("reset_sel", 32'({vsel, asel, shift, ALUop}), 32'd0);
    chk("reset_ir", 32'(sximm8), 32'h0);
    chk("reset_halted", 32'(halted), 32'd0);
    @(negedge clk);
    s       = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_w", 32'(w), 32'd1);
    chk("idle_ir", 32'(sximm8), 32'h0);

    // MOV R3,#-2
    push_w(3'd3, 1'b1);
    issue(16'hD3FE, 2, "mov_imm");
    chk("mov_imm_sximm8", 32'(sximm8), 32'h0000_FFFE);

    // ADD R2,R1,R0,LSL#1
    push_a(3'd1); push_b(3'd0, 2'b01); push_c(2'b00, 1'b0, 2'b01); push_w(3'd2, 1'b0);
    issue(16'hA148, 5, "add");

    // CMP R5,R6
    push_a(3'd5); push_b(3'd6, 2'b00); push_s(2'b01, 2'b00);
    issue(16'hAD06, 4, "cmp");

    // MOV R1,R2,LSR
    push_b(3'd2, 2'b10); push_c(2'b00, 1'b1, 2'b10); push_w(3'd1, 1'b0);
    issue(16'hC032, 4, "mov_reg");

    // AND R4,R3,R5,ASR
    push_a(3'd3); push_b(3'd5, 2'b11); push_c(2'b10, 1'b0, 2'b11); push_w(3'd4, 1'b0);
    issue(16'hB39D, 5, "and");

    // Illegal encodings: MOV with op=01 and opcode 000
    issue(16'hC800, 1, "illegal_mov");
    issue(16'h0000, 1, "illegal_opc");

    // Back-to-back: s held high across two MOV immediates
    push_w(3'd3, 1'b1); push_w(3'd5, 1'b1);
    @(negedge clk);
    s  = 1'b1;
    in = 16'hD3FE;
    @(posedge clk);
    #1;
    in = 16'hD57F;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_wait_w", 32'(w), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_reaccept_w", 32'(w), 32'd0);
    s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_done_w", 32'(w), 32'd1);
    chk("b2b_sximm8", 32'(sximm8), 32'h0000_007F);

    // MVN R7,R4 interrupted by reset during GET_B
    push_a(3'd0); push_b(3'd4, 2'b00);
    @(negedge clk);
    s  = 1'b1;
    in = 16'hB8E4;
    @(posedge clk);
    #1;
    s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_w", 32'(w), 32'd1);
    chk("midreset_strobes", 32'({loada, loadb, loadc, loads, write}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_w", 32'(w), 32'd1);

    // Opcode 111
`ifdef CPU_CTRL_HALT_EN
    @(negedge clk);
    s  = 1'b1;
    in = 16'hE000;
    @(posedge clk);
    #1;
    s = 1'b0;
    @(posedge clk);
    #1;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_w", 32'(w), 32'd0);
    @(negedge clk);
    s  = 1'b1;
    in = 16'hD3FE;
    repeat (3) @(posedge clk);
    #1;
    s = 1'b0;
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_sticky_w", 32'(w), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("halt_exit", 32'({halted, w}), 32'b01);
    @(negedge clk);
    reset_n = 1'b1;
`else
    issue(16'hE000, 1, "halt_illegal");
    chk("halt_tied", 32'(halted), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_ctrl.md
# cpu_ctrl

Instruction-sequencing controller for the lab datapath. It accepts one 16-bit instruction per start handshake, decodes it, and steps the register file, the A/B/C operand registers, the shifter, the ALU and the status register through a multi-cycle Moore state machine. It sits directly upstream of the ALU and is the sole source of its 2-bit operation select and of the status-register load strobe.

## Interface
- No parameters; widths are fixed: 16-bit instruction and data, 3-bit register index.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s  in  1  start request; sampled only in WAIT
- in  in  16  instruction word; captured into the IR on accept
- w  out  1  1 = idle in WAIT, ready to accept
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write enable
- vsel  out  1  write-data select: 0 = C register, 1 = sximm8
- sximm8  out  16  sign-extended IR[7:0]
- loada, loadb, loadc, loads  out  1 each  load strobes for A, B, C and status
- asel  out  1  1 = ALU Ain forced to 0
- shift  out  2  shifter control
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- halted  out  1  1 while in HALT; tied 0 when HALT is compiled out

## Operation
- IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], shift IR[4:3], Rm IR[2:0].
- Supported instructions:
  - MOV Rn,#im8: opcode 110, op 10.
  - MOV Rd,Rm{,sh}: opcode 110, op 00.
  - ADD/CMP/AND/MVN: opcode 101, op 00/01/10/11.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM, HALT.
- WAIT:
  - w=1.
  - s=1 at an edge: IR<=in, go to DECODE. s=0: stay.
- DECODE:
  - MOV imm -> WR_IMM.
  - MOV reg -> GET_B.
  - opcode 101 -> GET_A.
  - opcode 111 -> HALT (macro only).
  - Any other encoding -> WAIT with no strobes.
- GET_A: readnum=Rn, loada=1 -> GET_B.
- GET_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC:
  - ALUop=op for opcode 101, 00 for MOV reg.
  - asel=1 for MOV reg only.
  - CMP: loads=1, loadc=0 -> WAIT.
  - All others: loadc=1 -> WR_REG.
- WR_REG: writenum=Rd, vsel=0, write=1 -> WAIT.
- WR_IMM: writenum=Rn, vsel=1, write=1 -> WAIT.
- Field-driven outputs:
  - shift=IR[4:3] in GET_B and EXEC; 00 elsewhere.
  - sximm8 is always driven from the IR.
- Strobes not listed for a state are 0. Each strobe is high for exactly one cycle per instruction.
- Outputs are a pure function of state and IR; none depend on s or in combinationally.

## Timing
- Reset (asynchronous): state=WAIT, IR=0, w=1, halted=0, all strobes and selects 0.
- Reset mid-operation: all strobes drop immediately; no write or loads completes afterwards.
- Cycles from the accept edge to w=1 again:
  - MOV imm: 2
  - MOV reg: 4
  - CMP: 4
  - ADD/AND/MVN: 5
- s while busy is ignored, and in may change freely while busy.
- s held high gives back-to-back accepts: WAIT lasts exactly one cycle between instructions.

## Configuration
- CPU_CTRL_HALT_EN defined:
  - Opcode 111 enters HALT: w=0, halted=1, s ignored.
  - Only reset_n exits HALT.
- CPU_CTRL_HALT_EN undefined:
  - Opcode 111 is illegal: DECODE -> WAIT, no strobes.
  - halted is constant 0.

## Structure
- Shared package cpu_pkg:
  - state enum
  - opcode constants OPC_MOV=110, OPC_ALU=101, OPC_HALT=111
  - ALUop constants ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN
  - vsel constants VSEL_C, VSEL_IMM
- One sub-module, instr_dec: combinational field extraction and sign extension from the IR (opcode, op, Rn, Rd, Rm, shift, sximm8).
- The state register and output logic stay in cpu_ctrl.

## Test plan
- Reset: hold reset_n=0 with s=1 -> w=1, all strobes 0, IR unchanged. After release, nothing happens until an edge with s=1.
- MOV R3,#-2 (in=0xD3FE), pulse s:
  - Cycle 2 (WR_IMM): write=1, writenum=3, vsel=1, sximm8=0xFFFE.
  - w=1 on the next cycle.
- ADD R2,R1,R0,LSL#1 (0xA148) -> the following sequence, then w=1 five cycles after accept:
  - GET_A: readnum=1, loada=1.
  - GET_B: readnum=0, loadb=1, shift=01.
  - EXEC: ALUop=00, loadc=1.
  - WR_REG: writenum=2, write=1.
- CMP R5,R6 (0xAD06):
  - EXEC: ALUop=01, loads=1, loadc=0.
  - write never asserts; w=1 four cycles after accept.
- MVN R7,R4 (0xB8E4) with reset_n pulsed low during GET_B -> immediate WAIT, w=1, write never asserts.
- in=0xE000:
  - With the macro: halted=1, w=0; further s pulses ignored until reset.
  - Without the macro: WAIT after DECODE, all strobes 0 throughout.
